// File: rtl/run_launcher.sv
// run_launcher: host-side initiator for the processor req/done handshake.
// Preloads a data-memory window from a byte stream, pulses req, waits for
// done with a cycle counter and timeout, then streams a result window out.
module run_launcher #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int CW        = 16,
    parameter int LD_BASE   = 0,
    parameter int LD_LEN    = 64,
    parameter int RD_BASE   = 64,
    parameter int RD_LEN    = 16,
    parameter int TIMEOUT   = 4000,
    parameter int DONE_MASK = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          req,
    input  logic          done,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          finished,
    output logic          timed_out,
    output logic [CW-1:0] cycles
);

    // idx is one bit wider than an address so a full 2**AW window can be counted
    localparam int IW = AW + 1;

    localparam logic [IW-1:0] LD_LAST   = IW'(LD_LEN - 1);
    localparam logic [IW-1:0] RD_LAST   = IW'(RD_LEN - 1);
    localparam logic [AW-1:0] LD_BASE_A = AW'(LD_BASE);
    localparam logic [AW-1:0] RD_BASE_A = AW'(RD_BASE);
    localparam logic [CW:0]   TMO_W     = (CW + 1)'(TIMEOUT);
    localparam logic [CW-1:0] MASK_W    = CW'(DONE_MASK);
    localparam logic [CW-1:0] CYC_MAX   = '1;
    localparam logic          SKIP_LOAD = (LD_LEN == 0);
    localparam logic          SKIP_DUMP = (RD_LEN == 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REQ,
        ST_WAIT,
        ST_DUMP,
        ST_FIN
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   mask_cnt;

    logic            start_ok;
    logic            ld_hs;
    logic            rd_hs;
    logic            load_last;
    logic            dump_last;
    logic            done_ok;
    logic [CW-1:0]   cycles_inc;
    logic            timeout_hit;
    logic [AW-1:0]   ld_ptr;
    logic [AW-1:0]   rd_ptr;

    // Handshake, counter and address decode shared by next-state and datapath
    always_comb begin
        start_ok    = (state == ST_IDLE) && start && !abort;
        ld_hs       = (state == ST_LOAD) && ld_valid && !abort;
        rd_hs       = (state == ST_DUMP) && rd_ready && !abort;
        load_last   = (idx == LD_LAST);
        dump_last   = (idx == RD_LAST);
        done_ok     = done && (mask_cnt >= MASK_W);
        cycles_inc  = (cycles == CYC_MAX) ? cycles : cycles + CW'(1);
        timeout_hit = ({1'b0, cycles_inc} >= TMO_W);
        ld_ptr      = LD_BASE_A + idx[AW-1:0];
        rd_ptr      = RD_BASE_A + idx[AW-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_n = SKIP_LOAD ? ST_REQ : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (ld_hs && load_last) begin
                        state_n = ST_REQ;
                    end
                end
                ST_REQ: begin
                    state_n = ST_WAIT;
                end
                ST_WAIT: begin
                    // an unmasked done takes priority over a coincident timeout
                    if (done_ok) begin
                        state_n = SKIP_DUMP ? ST_FIN : ST_DUMP;
                    end else if (timeout_hit) begin
                        state_n = ST_FIN;
                    end
                end
                ST_DUMP: begin
                    if (rd_hs && dump_last) begin
                        state_n = ST_FIN;
                    end
                end
                ST_FIN: begin
                    state_n = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Window index, WAIT cycle counter, done mask counter and sticky timeout flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx       <= '0;
            cycles    <= '0;
            mask_cnt  <= '0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        idx       <= '0;
                        cycles    <= '0;
                        timed_out <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (ld_hs) begin
                        idx <= load_last ? '0 : idx + IW'(1);
                    end
                end
                ST_REQ: begin
                    mask_cnt <= '0;
                end
                ST_WAIT: begin
                    if (!abort) begin
                        cycles <= cycles_inc;
                        if (mask_cnt < MASK_W) begin
                            mask_cnt <= mask_cnt + CW'(1);
                        end
                        if (!done_ok && timeout_hit) begin
                            timed_out <= 1'b1;
                        end
                    end
                end
                ST_DUMP: begin
                    if (rd_hs) begin
                        idx <= dump_last ? '0 : idx + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Moore/handshake outputs; abort suppresses every strobe in the same cycle
    always_comb begin
        ld_ready  = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        req       = 1'b0;
        rd_valid  = 1'b0;
        rd_addr   = '0;
        rd_data   = '0;
        finished  = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_LOAD: begin
                ld_ready  = !abort;
                mem_wr_en = ld_hs;
                mem_addr  = ld_ptr;
                mem_wdata = ld_data;
            end
            ST_REQ: begin
                req = !abort;
            end
            ST_DUMP: begin
                rd_valid = !abort;
                mem_addr = rd_ptr;
                rd_addr  = rd_ptr;
                rd_data  = mem_rdata;
            end
            ST_FIN: begin
                finished = !abort;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_run_launcher.sv
// Directed bench for run_launcher: load, req, done/mask/timeout, dump with
// back-pressure, abort during load and reset mid-run.
module tb_run_launcher;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          req;
    logic          done;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          finished;
    logic          timed_out;
    logic [CW-1:0] cycles;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] mem [0:255];
    int wr_count;
    int req_count;
    int fin_count;

    always #5 clk = ~clk;

    run_launcher #(
        .AW(AW), .DW(DW), .CW(CW),
        .LD_BASE(0), .LD_LEN(4), .RD_BASE(64), .RD_LEN(16),
        .TIMEOUT(20), .DONE_MASK(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .req(req), .done(done),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .finished(finished), .timed_out(timed_out), .cycles(cycles)
    );

    // Data memory model: combinational read; result window 64..79 holds A0+offset
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= (i >= 64 && i < 80) ? 8'(8'hA0 + (i - 64)) : 8'h00;
            end
            wr_count  <= 0;
            req_count <= 0;
            fin_count <= 0;
        end else begin
            if (mem_wr_en) begin
                mem[mem_addr] <= mem_wdata;
                wr_count <= wr_count + 1;
            end
            if (req)      req_count <= req_count + 1;
            if (finished) fin_count <= fin_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Four back-to-back LOAD handshakes, byte k of words goes to address k
    task automatic load4(input string tag, input logic [31:0] words);
        for (int k = 0; k < 4; k++) begin
            step();
            start    = 1'b0;
            ld_valid = 1'b1;
            ld_data  = words[8*k +: 8];
            #1;
            chk({tag, "_ld_ready"}, 32'(ld_ready), 1);
            chk({tag, "_wr_en"}, 32'(mem_wr_en), 1);
            chk({tag, "_addr"}, 32'(mem_addr), k);
            chk({tag, "_wdata"}, 32'(mem_wdata), 32'(words[8*k +: 8]));
            chk({tag, "_no_req"}, 32'(req), 0);
        end
    endtask

    // The REQ cycle: single req pulse, no load strobes
    task automatic req_cycle(input string tag);
        step();
        ld_valid = 1'b0;
        #1;
        chk({tag, "_req"}, 32'(req), 1);
        chk({tag, "_req_wr_en"}, 32'(mem_wr_en), 0);
        chk({tag, "_req_ld_ready"}, 32'(ld_ready), 0);
        chk({tag, "_req_busy"}, 32'(busy), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation reached %0t without completing", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; ld_valid = 1'b0;
        ld_data = '0; done = 1'b0; rd_ready = 1'b0;

        // ---- reset state
        step(); step(); #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req", 32'(req), 0);
        chk("rst_ld_ready", 32'(ld_ready), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_finished", 32'(finished), 0);
        chk("rst_timed_out", 32'(timed_out), 0);
        chk("rst_cycles", 32'(cycles), 0);
        chk("rst_wr_en", 32'(mem_wr_en), 0);

        // ---- test 1: load 11,22,33,44 then req pulse
        step(); reset = 1'b1; start = 1'b1; #1;
        chk("t1_idle_busy", 32'(busy), 0);
        load4("t1", 32'h44332211);
        req_cycle("t1");
        chk("t1_mem0", 32'(mem[0]), 32'h11);
        chk("t1_mem1", 32'(mem[1]), 32'h22);
        chk("t1_mem2", 32'(mem[2]), 32'h33);
        chk("t1_mem3", 32'(mem[3]), 32'h44);

        // ---- test 2: done on the 10th WAIT cycle, full dump
        for (int w = 1; w <= 10; w++) begin
            step(); done = (w == 10); start = (w == 5); #1;
            chk("t2_wait_rd_valid", 32'(rd_valid), 0);
            chk("t2_wait_cycles", 32'(cycles), w - 1);
        end
        for (int k = 0; k < 16; k++) begin
            step(); done = 1'b0; start = 1'b0; rd_ready = 1'b1; #1;
            chk("t2_rd_valid", 32'(rd_valid), 1);
            chk("t2_rd_addr", 32'(rd_addr), 64 + k);
            chk("t2_mem_addr", 32'(mem_addr), 64 + k);
            chk("t2_rd_data", 32'(rd_data), 32'hA0 + k);
            chk("t2_dump_wr_en", 32'(mem_wr_en), 0);
            chk("t2_cycles", 32'(cycles), 10);
        end
        step(); rd_ready = 1'b0; #1;
        chk("t2_finished", 32'(finished), 1);
        chk("t2_fin_rd_valid", 32'(rd_valid), 0);
        chk("t2_timed_out", 32'(timed_out), 0);
        chk("t2_fin_cycles", 32'(cycles), 10);
        step(); #1;
        chk("t2_finished_once", 32'(finished), 0);
        chk("t2_idle", 32'(busy), 0);
        chk("t2_hold_cycles", 32'(cycles), 10);

        // ---- test 3: stalled load, stale done masked, dump with rd_ready 1,0,0,1
        step(); start = 1'b1; #1;
        step(); start = 1'b0; ld_valid = 1'b0; done = 1'b1; #1;
        chk("t3_stall_ld_ready", 32'(ld_ready), 1);
        chk("t3_stall_wr_en", 32'(mem_wr_en), 0);
        chk("t3_stall_addr", 32'(mem_addr), 0);
        load4("t3", 32'h88776655);
        req_cycle("t3");
        for (int w = 1; w <= 3; w++) begin
            step(); #1;
            chk("t3_mask_rd_valid", 32'(rd_valid), 0);
            chk("t3_mask_busy", 32'(busy), 1);
        end
        step(); done = 1'b0; rd_ready = 1'b1; #1;
        chk("t3_cycles", 32'(cycles), 3);
        chk("t3_rd_addr0", 32'(rd_addr), 64);
        chk("t3_rd_data0", 32'(rd_data), 32'hA0);
        step(); rd_ready = 1'b0; #1;
        chk("t3_stall1_addr", 32'(rd_addr), 65);
        chk("t3_stall1_data", 32'(rd_data), 32'hA1);
        chk("t3_stall1_valid", 32'(rd_valid), 1);
        step(); rd_ready = 1'b0; #1;
        chk("t3_stall2_addr", 32'(rd_addr), 65);
        chk("t3_stall2_data", 32'(rd_data), 32'hA1);
        step(); rd_ready = 1'b1; #1;
        chk("t3_resume_addr", 32'(rd_addr), 65);
        chk("t3_resume_data", 32'(rd_data), 32'hA1);
        for (int k = 2; k < 16; k++) begin
            step(); rd_ready = 1'b1; #1;
            chk("t3_rd_addr", 32'(rd_addr), 64 + k);
            chk("t3_rd_data", 32'(rd_data), 32'hA0 + k);
        end
        step(); rd_ready = 1'b0; #1;
        chk("t3_finished", 32'(finished), 1);
        chk("t3_fin_cycles", 32'(cycles), 3);
        chk("t3_timed_out", 32'(timed_out), 0);
        step(); #1;
        chk("t3_idle", 32'(busy), 0);

        // ---- test 4: done never rises, timeout after 20 WAIT cycles
        step(); start = 1'b1; #1;
        load4("t4", 32'hCCBBAA99);
        req_cycle("t4");
        for (int w = 1; w <= 20; w++) begin
            step(); #1;
            chk("t4_wait_rd_valid", 32'(rd_valid), 0);
            chk("t4_wait_finished", 32'(finished), 0);
            chk("t4_wait_cycles", 32'(cycles), w - 1);
        end
        step(); #1;
        chk("t4_finished", 32'(finished), 1);
        chk("t4_timed_out", 32'(timed_out), 1);
        chk("t4_cycles", 32'(cycles), 20);
        chk("t4_rd_valid", 32'(rd_valid), 0);
        step(); #1;
        chk("t4_idle", 32'(busy), 0);
        chk("t4_sticky", 32'(timed_out), 1);

        // ---- test 6: abort during LOAD after 2 writes, then restart at LD_BASE
        step(); start = 1'b1; #1;
        chk("t6_sticky_before_start", 32'(timed_out), 1);
        step(); start = 1'b0; ld_valid = 1'b1; ld_data = 8'hD1; #1;
        chk("t6_timed_out_cleared", 32'(timed_out), 0);
        chk("t6_cycles_cleared", 32'(cycles), 0);
        chk("t6_addr0", 32'(mem_addr), 0);
        step(); ld_data = 8'hD2; #1;
        chk("t6_addr1", 32'(mem_addr), 1);
        step(); ld_data = 8'hEE; abort = 1'b1; #1;
        chk("t6_abort_ld_ready", 32'(ld_ready), 0);
        chk("t6_abort_wr_en", 32'(mem_wr_en), 0);
        chk("t6_abort_busy", 32'(busy), 1);
        step(); abort = 1'b0; ld_valid = 1'b0; #1;
        chk("t6_idle", 32'(busy), 0);
        chk("t6_no_finished", 32'(finished), 0);
        chk("t6_no_req", 32'(req), 0);
        step(); start = 1'b1; #1;
        step(); start = 1'b0; ld_valid = 1'b1; ld_data = 8'hD3; #1;
        chk("t6_restart_addr", 32'(mem_addr), 0);
        chk("t6_restart_wdata", 32'(mem_wdata), 32'hD3);
        chk("t6_restart_wr_en", 32'(mem_wr_en), 1);
        step(); ld_valid = 1'b0; abort = 1'b1; #1;
        chk("t6_abort2_req", 32'(req), 0);
        step(); abort = 1'b0; #1;
        chk("t6_abort2_idle", 32'(busy), 0);

        // ---- memory contents and event totals across all runs
        chk("end_mem0", 32'(mem[0]), 32'hD3);
        chk("end_mem1", 32'(mem[1]), 32'hD2);
        chk("end_mem2", 32'(mem[2]), 32'hBB);
        chk("end_mem3", 32'(mem[3]), 32'hCC);
        chk("end_mem64", 32'(mem[64]), 32'hA0);
        chk("end_wr_count", 32'(wr_count), 15);
        chk("end_req_count", 32'(req_count), 3);
        chk("end_fin_count", 32'(fin_count), 3);

        // ---- reset asserted mid-LOAD: write strobe drops at once
        step(); start = 1'b1; #1;
        step(); start = 1'b0; ld_valid = 1'b1; ld_data = 8'hFF; #1;
        chk("rstmid_wr_en_before", 32'(mem_wr_en), 1);
        reset = 1'b0; #1;
        chk("rstmid_wr_en", 32'(mem_wr_en), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_ld_ready", 32'(ld_ready), 0);
        step(); reset = 1'b1; ld_valid = 1'b0; #1;
        chk("rstmid_idle", 32'(busy), 0);
        chk("rstmid_cycles", 32'(cycles), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
